// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: FU result inputs, flush inputs, CDB output.
// slave = arbiter side, master = FU / pipeline side.
interface wb_arbiter_if #(
  parameter int PREG_W = 7,
  parameter int TAG_W  = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [TAG_W-1:0]  alu_rob_tag;
  logic [PREG_W-1:0] alu_pd;
  logic              alu_we;
  logic [31:0]       alu_result;

  logic              b_valid;
  logic              b_ready;
  logic [TAG_W-1:0]  b_rob_tag;
  logic [PREG_W-1:0] b_pd;
  logic              b_we;
  logic [31:0]       b_result;

  logic              mem_valid;
  logic              mem_ready;
  logic [TAG_W-1:0]  mem_rob_tag;
  logic [PREG_W-1:0] mem_pd;
  logic              mem_we;
  logic [31:0]       mem_result;

  logic [TAG_W-1:0]  rob_head;
  logic              mispredict;
  logic [TAG_W-1:0]  mispredict_tag;

  logic              cdb_valid;
  logic [1:0]        cdb_src;
  logic [TAG_W-1:0]  cdb_rob_tag;
  logic [PREG_W-1:0] cdb_pd;
  logic              cdb_we;
  logic [31:0]       cdb_data;

  modport slave (
    input  alu_valid, alu_rob_tag, alu_pd,
    input  alu_we, alu_result,
    output alu_ready,
    input  b_valid, b_rob_tag, b_pd,
    input  b_we, b_result,
    output b_ready,
    input  mem_valid, mem_rob_tag, mem_pd,
    input  mem_we, mem_result,
    output mem_ready,
    input  rob_head, mispredict, mispredict_tag,
    output cdb_valid, cdb_src, cdb_rob_tag,
    output cdb_pd, cdb_we, cdb_data
  );

  modport master (
    output alu_valid, alu_rob_tag, alu_pd,
    output alu_we, alu_result,
    input  alu_ready,
    output b_valid, b_rob_tag, b_pd,
    output b_we, b_result,
    input  b_ready,
    output mem_valid, mem_rob_tag, mem_pd,
    output mem_we, mem_result,
    input  mem_ready,
    output rob_head, mispredict, mispredict_tag,
    input  cdb_valid, cdb_src, cdb_rob_tag,
    input  cdb_pd, cdb_we, cdb_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-FU result FIFOs, round-robin grant
// onto a registered CDB, squash of results younger than a mispredict.
module wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int PREG_W = 7,
  parameter int TAG_W  = 5
) (
  input  logic        clk,
  input  logic        reset,
  wb_arbiter_if.slave bus
);

  localparam int NS = 3;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_BR  = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;

  // age relative to the ROB head; larger age = younger
  function automatic logic younger(
    input logic [TAG_W-1:0] t,
    input logic [TAG_W-1:0] hd,
    input logic [TAG_W-1:0] ma
  );
    logic [TAG_W-1:0] a;
    a = t - hd;
    return a > ma;
  endfunction

  logic              in_vld  [NS];
  logic [TAG_W-1:0]  in_tag  [NS];
  logic [PREG_W-1:0] in_pd   [NS];
  logic              in_we   [NS];
  logic [31:0]       in_data [NS];

  logic [DEPTH-1:0]  slot_q [NS];
  logic [DEPTH-1:0]  slot_d [NS];
  logic [TAG_W-1:0]  tag_q  [NS][DEPTH];
  logic [PREG_W-1:0] pd_q   [NS][DEPTH];
  logic              we_q   [NS][DEPTH];
  logic [31:0]       data_q [NS][DEPTH];
  logic [PW-1:0]     rd_q   [NS];
  logic [PW-1:0]     rd_d   [NS];
  logic [PW-1:0]     wr_q   [NS];
  logic [PW-1:0]     wr_d   [NS];
  logic [CW-1:0]     cnt_q  [NS];
  logic [CW-1:0]     cnt_d  [NS];

  logic [1:0]        rr_q;
  logic [1:0]        rr_d;

  logic              cv_q;
  logic              cv_d;
  logic [1:0]        csrc_q;
  logic [1:0]        csrc_d;
  logic [TAG_W-1:0]  ctag_q;
  logic [TAG_W-1:0]  ctag_d;
  logic [PREG_W-1:0] cpd_q;
  logic [PREG_W-1:0] cpd_d;
  logic              cwe_q;
  logic              cwe_d;
  logic [31:0]       cdat_q;
  logic [31:0]       cdat_d;

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  mt_age;
  logic              flush;

  logic [NS-1:0]     rdy;
  logic [NS-1:0]     push;
  logic [NS-1:0]     pop;
  logic [NS-1:0]     live;
  logic [NS-1:0]     dead;
  logic [NS-1:0]     gnt;
  logic              in_kill [NS];

  logic [TAG_W-1:0]  hd_tag  [NS];
  logic [PREG_W-1:0] hd_pd   [NS];
  logic              hd_we   [NS];
  logic [31:0]       hd_data [NS];

  logic [2:0][1:0]   ord;
  logic              found;
  logic [1:0]        win;

  assign head   = bus.rob_head;
  assign flush  = bus.mispredict;
  assign mt_age = bus.mispredict_tag - bus.rob_head;

  // gather the three FU result ports into source-indexed arrays
  always_comb begin
    in_vld[SRC_ALU]  = bus.alu_valid;
    in_tag[SRC_ALU]  = bus.alu_rob_tag;
    in_pd[SRC_ALU]   = bus.alu_pd;
    in_we[SRC_ALU]   = bus.alu_we;
    in_data[SRC_ALU] = bus.alu_result;
    in_vld[SRC_BR]   = bus.b_valid;
    in_tag[SRC_BR]   = bus.b_rob_tag;
    in_pd[SRC_BR]    = bus.b_pd;
    in_we[SRC_BR]    = bus.b_we;
    in_data[SRC_BR]  = bus.b_result;
    in_vld[SRC_MEM]  = bus.mem_valid;
    in_tag[SRC_MEM]  = bus.mem_rob_tag;
    in_pd[SRC_MEM]   = bus.mem_pd;
    in_we[SRC_MEM]   = bus.mem_we;
    in_data[SRC_MEM] = bus.mem_result;
  end

  // head view, liveness and handshake per source
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      hd_tag[s]  = tag_q[s][rd_q[s]];
      hd_pd[s]   = pd_q[s][rd_q[s]];
      hd_we[s]   = we_q[s][rd_q[s]];
      hd_data[s] = data_q[s][rd_q[s]];
      rdy[s]     = cnt_q[s] < CW'(DEPTH);
      push[s]    = in_vld[s] & rdy[s];
      in_kill[s] = flush &
                   younger(in_tag[s], head, mt_age);
      live[s]    = (cnt_q[s] != '0) &
                   slot_q[s][rd_q[s]] &
                   !(flush &
                     younger(hd_tag[s], head, mt_age));
      dead[s]    = (cnt_q[s] != '0) &
                   !slot_q[s][rd_q[s]];
    end
  end

  // round-robin search order starting at the pointer
  always_comb begin
    ord = {2'd2, 2'd1, 2'd0};
    unique case (1'b1)
      rr_q == 2'd1: ord = {2'd0, 2'd2, 2'd1};
      rr_q == 2'd2: ord = {2'd1, 2'd0, 2'd2};
      default:      ord = {2'd2, 2'd1, 2'd0};
    endcase
  end

  // pick the first live head in search order
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    for (int i = 0; i < NS; i++) begin
      if (!found && live[ord[i]]) begin
        found = 1'b1;
        win   = ord[i];
      end
    end
    gnt  = '0;
    rr_d = rr_q;
    if (found) begin
      gnt[win] = 1'b1;
      rr_d     = (win == 2'd2) ? 2'd0
                               : win + 2'd1;
    end
  end

  assign pop = gnt | dead;

  // FIFO pointer, count and slot-valid next state
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      slot_d[s] = slot_q[s];
      rd_d[s]   = rd_q[s];
      wr_d[s]   = wr_q[s];
      if (flush) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (younger(tag_q[s][e], head, mt_age))
            slot_d[s][e] = 1'b0;
        end
      end
      if (pop[s]) begin
        slot_d[s][rd_q[s]] = 1'b0;
        rd_d[s] = rd_q[s] + PW'(1);
      end
      if (push[s]) begin
        slot_d[s][wr_q[s]] = !in_kill[s];
        wr_d[s] = wr_q[s] + PW'(1);
      end
      cnt_d[s] = cnt_q[s] + CW'(push[s])
                          - CW'(pop[s]);
    end
  end

  // CDB register load from the granted head
  always_comb begin
    cv_d   = found;
    csrc_d = csrc_q;
    ctag_d = ctag_q;
    cpd_d  = cpd_q;
    cwe_d  = cwe_q;
    cdat_d = cdat_q;
    if (found) begin
      csrc_d = win;
      ctag_d = hd_tag[win];
      cpd_d  = hd_pd[win];
      cwe_d  = hd_we[win];
      cdat_d = hd_data[win];
    end
  end

  // payload storage written at the tail on enqueue
  always_ff @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (push[s]) begin
        tag_q[s][wr_q[s]]  <= in_tag[s];
        pd_q[s][wr_q[s]]   <= in_pd[s];
        we_q[s][wr_q[s]]   <= in_we[s];
        data_q[s][wr_q[s]] <= in_data[s];
      end
    end
  end

  // control state: FIFO bookkeeping, pointer, CDB register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NS; s++) begin
        slot_q[s] <= '0;
        rd_q[s]   <= '0;
        wr_q[s]   <= '0;
        cnt_q[s]  <= '0;
      end
      rr_q   <= 2'd0;
      cv_q   <= 1'b0;
      csrc_q <= 2'd0;
      ctag_q <= '0;
      cpd_q  <= '0;
      cwe_q  <= 1'b0;
      cdat_q <= '0;
    end else begin
      for (int s = 0; s < NS; s++) begin
        slot_q[s] <= slot_d[s];
        rd_q[s]   <= rd_d[s];
        wr_q[s]   <= wr_d[s];
        cnt_q[s]  <= cnt_d[s];
      end
      rr_q   <= rr_d;
      cv_q   <= cv_d;
      csrc_q <= csrc_d;
      ctag_q <= ctag_d;
      cpd_q  <= cpd_d;
      cwe_q  <= cwe_d;
      cdat_q <= cdat_d;
    end
  end

  assign bus.alu_ready   = rdy[SRC_ALU];
  assign bus.b_ready     = rdy[SRC_BR];
  assign bus.mem_ready   = rdy[SRC_MEM];
  assign bus.cdb_valid   = cv_q;
  assign bus.cdb_src     = csrc_q;
  assign bus.cdb_rob_tag = ctag_q;
  assign bus.cdb_pd      = cpd_q;
  assign bus.cdb_we      = cv_q & cwe_q;
  assign bus.cdb_data    = cdat_q;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single CDB / PRF write port among the three functional units: ALU (src 0), branch (src 1) and memory (src 2).
- Each FU result is captured in a small per-source FIFO. One result per cycle is granted round-robin and driven on a registered CDB output.
- Results younger than a resolved mispredict are squashed while buffered, in flight or at the output register.
- Sits between the FU outputs and the PRF write port, ROB completion and RS wakeup.

Parameters:
DEPTH, 2, entries per source FIFO (power of 2, ≥2)
PREG_W, 7, physical register index width
TAG_W, 5, ROB tag width (ROB has 2**TAG_W entries)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
alu_valid / b_valid / mem_valid  input  1 each  FU result valid
alu_ready / b_ready / mem_ready  output  1 each  source FIFO can accept
alu_rob_tag / b_rob_tag / mem_rob_tag  input  TAG_W each  ROB tag of result
alu_pd / b_pd / mem_pd  input  PREG_W each  destination physical reg
alu_we / b_we / mem_we  input  1 each  result writes a register (0 for stores and branches without rd)
alu_result / b_result / mem_result  input  32 each  result data
rob_head  input  TAG_W  oldest ROB entry
mispredict  input  1  flush pulse
mispredict_tag  input  TAG_W  tag of mispredicted branch
cdb_valid  output  1  broadcast valid
cdb_src  output  2  granted source (0 alu, 1 branch, 2 mem)
cdb_rob_tag  output  TAG_W  broadcast ROB tag
cdb_pd  output  PREG_W  broadcast destination
cdb_we  output  1  PRF write enable (valid & we)
cdb_data  output  32  broadcast data

Behaviour:
- Reset (async, any time, including mid-operation):
  - all FIFOs empty; every slot-valid bit cleared
  - cdb_valid=0, cdb_we=0; cdb_src, cdb_rob_tag, cdb_pd, cdb_data = 0
  - round-robin pointer = 0; *_ready = 1 after reset deasserts
- Enqueue: X_valid && X_ready at a clk edge writes the FIFO tail.
  - X_ready = (count_X < DEPTH). It is derived from registered count only and does not depend on this cycle's grant.
  - A full FIFO does not accept, even if it pops in the same cycle.
- Age: age(t) = (t - rob_head) mod 2**TAG_W. An entry is younger than the branch iff age(tag) > age(mispredict_tag).
- Flush, in the cycle mispredict=1:
  - every stored younger entry has its slot-valid bit cleared
  - an incoming younger enqueue is accepted (handshake completes) but stored invalid
  - entries with tag == mispredict_tag and all older entries are kept
  - if the entry being loaded into the CDB register this cycle is younger, the load is suppressed and cdb_valid=0 next cycle
  - an already-registered cdb output is not retracted
- Arbitration, combinational each cycle, over FIFOs whose head slot is valid and not being killed this cycle:
  - search starts at the pointer, order 0→1→2 with wrap
  - the winner's head is popped and registered to cdb_* at the next edge; cdb_valid=1 for exactly one cycle per grant
  - the pointer becomes (winner+1) mod 3; no winner leaves it unchanged
- Dead heads: a head with slot-valid=0 is popped in the same cycle with no grant consumed. Only heads are examined (one dead pop per FIFO per cycle).
- Latency: enqueue into an empty FIFO at edge N → cdb_valid at edge N+1 if granted. Worst case with all sources busy is 3 cycles.
- cdb_* outputs are registered. cdb_we = 1 only when cdb_valid and the stored we = 1.
- Simultaneous enqueue and pop on one FIFO: count unchanged; pointers wrap modulo DEPTH.
- Order is preserved per source; no ordering is imposed across sources.

Test Plan:
- Reset, then ALU enq tag 3, pd 10, data 0xDEAD, we 1 → next cycle cdb_valid=1, cdb_src=0, cdb_pd=10, cdb_data=0xDEAD, cdb_we=1; following cycle cdb_valid=0.
- All three sources enqueue every cycle for 6 cycles → cdb_src sequence 0,1,2,0,1,2. Each *_ready drops when count hits 2 and no result is lost or duplicated.
- Mem enq with we=0 (store) → cdb_valid=1, cdb_we=0.
- rob_head=30; buffered tags 31 (alu), 2 (mem), 1 (branch); mispredict_tag=1 → tag 2 discarded; 31 and 1 broadcast; tag 2 never appears.
- Mispredict same cycle as b_valid with younger tag and as CDB load of a younger entry → b_ready stays 1, nothing broadcast for either, cdb_valid=0 next cycle.
- Assert reset with all FIFOs full and cdb_valid=1 → all outputs 0 immediately (async). After release the first grant goes to src 0.
